// File: rtl/vga_from_memory.sv
// vga_from_memory: 640x480@60 VGA timing with 1-clock-latency stripe memory prefetch.
// Optional VGA_GRAYSCALE_EN: replicate data to all channels; otherwise expand RGB332.
module vga_from_memory (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  output logic [3:0]  addr,
  output logic        vga_clock,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [23:0] rgb
);
  logic [9:0]  h, v, h_nxt, v_nxt;
  logic [5:0]  sub, sub_nxt;
  logic [3:0]  addr_nxt;
  logic        blank_nxt;
  logic [23:0] pix;
  always_comb begin
    h_nxt     = (h == 10'd799) ? 10'd0 : h + 10'd1;
    v_nxt     = (h != 10'd799) ? v : (v == 10'd524) ? 10'd0 : v + 10'd1;
    blank_nxt = (h_nxt < 10'd640) && (v_nxt < 10'd480);
    // sub/addr track column h_nxt+1; column 799 looks ahead to stripe 0
    sub_nxt   = (h_nxt == 10'd799) ? 6'd0 :
                (h_nxt < 10'd639) ? ((sub == 6'd39) ? 6'd0 : sub + 6'd1) : sub;
    addr_nxt  = (h_nxt < 10'd639) ? ((sub == 6'd39) ? addr + 4'd1 : addr) : 4'd0;
`ifdef VGA_GRAYSCALE_EN
    pix       = {data, data, data};
`else
    pix       = {data[7:5], data[7:5], data[7:6],
                 data[4:2], data[4:2], data[4:3],
                 data[1:0], data[1:0], data[1:0], data[1:0]};
`endif
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vga_clock <= 1'b0;
      h         <= 10'd799;
      v         <= 10'd524;
      sub       <= 6'd0;
      addr      <= 4'd0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      blank     <= 1'b0;
      rgb       <= '0;
    end else begin
      vga_clock <= ~vga_clock;
      if (vga_clock) begin
        h     <= h_nxt;
        v     <= v_nxt;
        sub   <= sub_nxt;
        addr  <= addr_nxt;
        hsync <= !((h_nxt >= 10'd656) && (h_nxt <= 10'd751));
        vsync <= !((v_nxt >= 10'd490) && (v_nxt <= 10'd491));
        blank <= blank_nxt;
        rgb   <= blank_nxt ? pix : 24'd0;
      end
    end
  end
endmodule

// File: tb/tb_vga_from_memory.sv
// tb_vga_from_memory: random/stripe memory contents checked against a pixel-position model.
module tb_vga_from_memory;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data = 8'd0;
  logic [3:0]  addr;
  logic        vga_clock, hsync, vsync, blank;
  logic [23:0] rgb;
  logic [7:0]  mem [16];
  int asserts = 0;
  int fails = 0;
  int e = 0;

  typedef struct packed {
    logic vc, hs, vs, bl;
    logic [3:0] ad;
    logic [23:0] c;
  } exp_t;

  vga_from_memory dut (
    .clock(clock), .reset(reset), .data(data), .addr(addr),
    .vga_clock(vga_clock), .hsync(hsync), .vsync(vsync), .blank(blank), .rgb(rgb)
  );

  always #5 clock = ~clock;
  always @(posedge clock) data <= mem[addr];

  function automatic logic [23:0] expand(input logic [7:0] d);
`ifdef VGA_GRAYSCALE_EN
    return {d, d, d};
`else
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
`endif
  endfunction

  function automatic logic [3:0] stripe(input int c);
    return (c < 640) ? 4'(c / 40) : 4'd0;
  endfunction

  // Expected outputs after clock edge ec since reset release; advance k enters pixel k-1.
  function automatic exp_t model(input int ec);
    exp_t x;
    int k, p, h, v;
    k = ec / 2;
    x.vc = 1'(ec % 2);
    if (k == 0) begin
      x.hs = 1'b1; x.vs = 1'b1; x.bl = 1'b0; x.ad = 4'd0; x.c = 24'd0;
    end else begin
      p = k - 1;
      h = p % 800;
      v = (p / 800) % 525;
      x.hs = !(h >= 656 && h <= 751);
      x.vs = !(v >= 490 && v <= 491);
      x.bl = (h < 640) && (v < 480);
      x.ad = stripe((h + 1) % 800);
      x.c  = x.bl ? expand(mem[stripe(h)]) : 24'd0;
    end
    return x;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    e = 0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    e = 0;
    asserts++;
    if ({vga_clock, hsync, vsync, blank, addr, rgb} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 24'd0}) begin
      fails++;
      $display("FAIL reset_immediate: got vc=%b hs=%b vs=%b bl=%b addr=%h rgb=%h, need 0 1 1 0 0 000000",
               vga_clock, hsync, vsync, blank, addr, rgb);
    end
    repeat (3) @(posedge clock);
    #1;
    asserts++;
    if ({vga_clock, hsync, vsync, blank, addr, rgb} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 24'd0}) begin
      fails++;
      $display("FAIL reset_held: got vc=%b hs=%b vs=%b bl=%b addr=%h rgb=%h, need 0 1 1 0 0 000000",
               vga_clock, hsync, vsync, blank, addr, rgb);
    end
  endtask

  task automatic test_stripes();
    int h;
    logic [23:0] want;
    release_reset();
    repeat (1600) begin
      step();
      if (e % 2 == 0) begin
        h = (e / 2 - 1) % 800;
        want = (h < 640) ? expand(8'(16 * (h / 40))) : 24'd0;
        asserts++;
        if (rgb !== want || blank !== (h < 640)) begin
          fails++;
          if (fails < 30) $display("FAIL stripe col %0d: got rgb=%h blank=%b, need rgb=%h blank=%b", h, rgb, blank, want, h < 640);
        end
        if (h == 40 || h == 639) begin
          asserts++;
          if (rgb !== expand((h == 40) ? 8'h10 : 8'hF0)) begin
            fails++;
            $display("FAIL stripe_edge col %0d: got %h need %h", h, rgb, expand((h == 40) ? 8'h10 : 8'hF0));
          end
        end
      end
    end
  endtask

  task automatic test_lines(input int n);
    exp_t x;
    int hl, bh, first, line;
    for (int l = 0; l < n; l++) begin
      hl = 0; bh = 0; first = -1;
      line = (e / 1600) % 525;
      for (int i = 1; i <= 1600; i++) begin
        step();
        x = model(e);
        asserts++;
        if ({vga_clock, hsync, vsync, blank, addr, rgb} !== x) begin
          fails++;
          if (fails < 30) $display("FAIL stream edge %0d: got %h need %h", e, {vga_clock, hsync, vsync, blank, addr, rgb}, x);
        end
        if (!hsync) begin
          hl++;
          if (first < 0) first = i;
        end
        if (blank) bh++;
      end
      asserts++;
      if (hl != 192 || first != 1314) begin
        fails++;
        $display("FAIL hsync_width line %0d: got %0d clocks from %0d, need 192 from 1314", line, hl, first);
      end
      asserts++;
      if (bh != ((line < 480) ? 1280 : 0)) begin
        fails++;
        $display("FAIL blank_width line %0d: got %0d clocks need %0d", line, bh, (line < 480) ? 1280 : 0);
      end
    end
  endtask

  task automatic test_prefetch();
    int h;
    logic [3:0] want;
    repeat (1600) begin
      step();
      if (e % 2 == 0) begin
        h = (e / 2 - 1) % 800;
        if (h == 39 || h == 638 || h == 639 || h == 799) begin
          want = (h == 39) ? 4'd1 : (h == 638) ? 4'd15 : 4'd0;
          asserts++;
          if (addr !== want) begin
            fails++;
            $display("FAIL prefetch col %0d: got addr=%0d need %0d", h, addr, want);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(e % 2 == 0 && (e / 2 - 1) % 800 == 300) && guard < 1600) begin
      step();
      guard++;
    end
    asserts++;
    if (guard >= 1600) begin
      fails++;
      $display("FAIL mid_reset_reach: got no column 300 within 1600 clocks, need one");
    end
    #2 reset = 1'b0;
    #1;
    asserts++;
    if ({vga_clock, hsync, vsync, blank, addr, rgb} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 24'd0}) begin
      fails++;
      $display("FAIL mid_reset_async: got vc=%b hs=%b vs=%b bl=%b addr=%h rgb=%h, need 0 1 1 0 0 000000",
               vga_clock, hsync, vsync, blank, addr, rgb);
    end
    repeat (2) @(posedge clock);
    release_reset();
    test_lines(2);
  endtask

  task automatic test_color();
    exp_t x;
    logic [23:0] c0, c1;
`ifdef VGA_GRAYSCALE_EN
    c0 = 24'hE0E0E0; c1 = 24'h1C1C1C;
`else
    c0 = 24'hFF0000; c1 = 24'h00FF00;
`endif
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    mem[1] = 8'h1C;
    repeat (2) @(posedge clock);
    release_reset();
    repeat (1600) begin
      step();
      x = model(e);
      asserts++;
      if ({vga_clock, hsync, vsync, blank, addr, rgb} !== x) begin
        fails++;
        if (fails < 30) $display("FAIL color edge %0d: got %h need %h", e, {vga_clock, hsync, vsync, blank, addr, rgb}, x);
      end
      if (e == 2 || e == 82) begin
        asserts++;
        if (rgb !== ((e == 2) ? c0 : c1)) begin
          fails++;
          $display("FAIL color_const edge %0d: got %h need %h", e, rgb, (e == 2) ? c0 : c1);
        end
      end
    end
    test_lines(2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(16 * i);
    test_reset();
    test_stripes();
    test_lines(16);
    test_prefetch();
    test_mid_reset();
    test_color();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
